// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus an independent counting FSM per channel that turns
// raw pin levels into clean levels and registered one-cycle edge strobes.
`timescale 1ns/1ps
module input_debouncer #(
    parameter int NUM_CH          = 20,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    logic [NUM_CH-1:0] sync_p0;
    logic [NUM_CH-1:0] sync_p1;
    logic [NUM_CH-1:0] differ;

    state_t            state     [NUM_CH];
    state_t            state_nxt [NUM_CH];
    logic [CW-1:0]     cnt       [NUM_CH];
    logic [CW-1:0]     cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] db_nxt;
    logic [NUM_CH-1:0] rise_nxt;
    logic [NUM_CH-1:0] fall_nxt;

    // Stage p0/p1: metastability guard; only sync_p1 feeds the debounce logic
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    assign differ = sync_p1 ^ db_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state[ch] <= IDLE;
                cnt[ch]   <= '0;
            end
            db_out     <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state[ch] <= state_nxt[ch];
                cnt[ch]   <= cnt_nxt[ch];
            end
            db_out     <= db_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // Any cycle where the synchronised level matches db_out restarts the count
    always_comb begin
        db_nxt   = db_out;
        rise_nxt = '0;
        fall_nxt = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_nxt[ch] = state[ch];
            cnt_nxt[ch]   = cnt[ch];
            case (state[ch])
                IDLE: begin
                    if (differ[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            db_nxt[ch]   = sync_p1[ch];
                            rise_nxt[ch] = sync_p1[ch];
                            fall_nxt[ch] = ~sync_p1[ch];
                            cnt_nxt[ch]  = '0;
                        end else begin
                            state_nxt[ch] = COUNT;
                            cnt_nxt[ch]   = CW'(1);
                        end
                    end
                end
                COUNT: begin
                    if (!differ[ch]) begin
                        state_nxt[ch] = IDLE;
                        cnt_nxt[ch]   = '0;
                    end else if (cnt[ch] == CNT_MAX) begin
                        db_nxt[ch]    = sync_p1[ch];
                        rise_nxt[ch]  = sync_p1[ch];
                        fall_nxt[ch]  = ~sync_p1[ch];
                        state_nxt[ch] = IDLE;
                        cnt_nxt[ch]   = '0;
                    end else begin
                        cnt_nxt[ch] = cnt[ch] + CW'(1);
                    end
                end
                default: begin
                    state_nxt[ch] = IDLE;
                    cnt_nxt[ch]   = '0;
                end
            endcase
        end
    end

endmodule
